// File: rtl/mul_seq_interface.sv
// mul_seq_interface: sequential shift-add multiplier with start/ready handshake.
// Retires BITS_PER_CYCLE multiplier bits per busy cycle.
// Signed mode uses magnitude conversion, so latency is the same in both modes.
// Optional accumulate mode: define MUL_ACC_EN to add the mul_acc input.
module mul_seq_interface #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*WIDTH-1:0]   mul_ip_BA,
  input  logic                 mul_signed,
  input  logic                 mul_start,
`ifdef MUL_ACC_EN
  input  logic                 mul_acc,
`endif
  output logic                 mul_ready,
  output logic                 mul_done,
  output logic [2*WIDTH-1:0]   mul_op_prod
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  if ((WIDTH % BITS_PER_CYCLE) != 0 || WIDTH < 2) begin : g_bad_cfg
    $error("mul_seq_interface: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic                 launch, finish;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   sum;
  logic                 neg;
  logic [CW-1:0]        cnt;
`ifdef MUL_ACC_EN
  logic                 acc_en;
`endif

  logic [WIDTH-1:0]     a_in, b_in, a_mag, b_mag;
  logic                 neg_in;
  logic [2*WIDTH-1:0]   chunk, sum_nxt, result, writeback;

  assign a_in = mul_ip_BA[WIDTH-1:0];
  assign b_in = mul_ip_BA[2*WIDTH-1:WIDTH];

  // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which still fits in W unsigned bits.
  always_comb begin
    a_mag  = (mul_signed && a_in[WIDTH-1]) ? (~a_in + 1'b1) : a_in;
    b_mag  = (mul_signed && b_in[WIDTH-1]) ? (~b_in + 1'b1) : b_in;
    neg_in = mul_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
  end

  // Partial product for this cycle's multiplier bits and the completion value.
  always_comb begin
    chunk = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) chunk = chunk + (mcand << i);
    end
    sum_nxt = sum + chunk;
    result  = neg ? (~sum_nxt + 1'b1) : sum_nxt;
`ifdef MUL_ACC_EN
    writeback = acc_en ? (mul_op_prod + result) : result;
`else
    writeback = result;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic, handshake strobes and ready output.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    finish    = 1'b0;
    mul_ready = 1'b0;
    case (state)
      IDLE: begin
        mul_ready = 1'b1;
        if (mul_start) begin
          launch    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CW'(N - 1)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands at launch, shift-add while busy, write result on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand       <= '0;
      mplier      <= '0;
      sum         <= '0;
      neg         <= 1'b0;
      cnt         <= '0;
      mul_done    <= 1'b0;
      mul_op_prod <= '0;
`ifdef MUL_ACC_EN
      acc_en      <= 1'b0;
`endif
    end else begin
      mul_done <= finish;
      if (launch) begin
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
        sum    <= '0;
        neg    <= neg_in;
        cnt    <= '0;
`ifdef MUL_ACC_EN
        acc_en <= mul_acc;
`endif
      end else if (state == BUSY) begin
        mcand  <= mcand << BITS_PER_CYCLE;
        mplier <= mplier >> BITS_PER_CYCLE;
        sum    <= sum_nxt;
        cnt    <= cnt + CW'(1);
        if (finish) mul_op_prod <= writeback;
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_interface.sv
// Bench for mul_seq_interface: two instances (R=1 and R=4, W=8) share inputs
// and are checked against an integer-arithmetic reference model.
module tb_mul_seq_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ba;
  logic        sgn_in;
  logic        start;
`ifdef MUL_ACC_EN
  logic        acc_in;
`endif
  logic        ready1, done1, ready4, done4;
  logic [15:0] prod1, prod4;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_prod;

  always #5 clk = ~clk;

  mul_seq_interface #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .mul_ip_BA(ba), .mul_signed(sgn_in), .mul_start(start),
`ifdef MUL_ACC_EN
    .mul_acc(acc_in),
`endif
    .mul_ready(ready1), .mul_done(done1), .mul_op_prod(prod1));

  mul_seq_interface #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .mul_ip_BA(ba), .mul_signed(sgn_in), .mul_start(start),
`ifdef MUL_ACC_EN
    .mul_acc(acc_in),
`endif
    .mul_ready(ready4), .mul_done(done4), .mul_op_prod(prod4));

  // Reference: plain integer product, truncated to 16 bits.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    int sa, sb, p;
    sa = (sgn && a[7]) ? int'(a) - 256 : int'(a);
    sb = (sgn && b[7]) ? int'(b) - 256 : int'(b);
    p  = sa * sb;
    return p[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  // One operation from idle with start dropped after launch; checks latency,
  // single done pulse, result hold during busy and final product on both DUTs.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sgn, input logic ac);
    logic [15:0] prev, expv;
    int lat1, lat4, d1, d4;
    prev = exp_prod;
    expv = model(a, b, sgn);
`ifdef MUL_ACC_EN
    if (ac) expv = prev + expv;
`else
    if (ac) expv = expv;
`endif
    lat1 = 0; lat4 = 0; d1 = 0; d4 = 0;
    @(negedge clk);
    ba = {b, a}; sgn_in = sgn; start = 1'b1;
`ifdef MUL_ACC_EN
    acc_in = ac;
`endif
    @(posedge clk); #1;
    start = 1'b0; ba = 16'($urandom); sgn_in = 1'($urandom);
`ifdef MUL_ACC_EN
    acc_in = 1'($urandom);
`endif
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!ready1) begin
        lat1++;
        chk("hold1", prod1, prev);
      end
      if (!ready4) lat4++;
      if (done1) d1++;
      if (done4) d4++;
    end
    chk("lat1", 16'(lat1), 16'd8);
    chk("lat4", 16'(lat4), 16'd2);
    chk("done1_cnt", 16'(d1), 16'd1);
    chk("done4_cnt", 16'(d4), 16'd1);
    chk("prod1", prod1, expv);
    chk("prod4", prod4, expv);
    exp_prod = expv;
  endtask

  initial begin
    logic [5:0] rpat;
    int waited;
    logic [7:0] ra, rb;
    logic rs, rc;
    reset = 1'b0; start = 1'b0; ba = '0; sgn_in = 1'b0;
`ifdef MUL_ACC_EN
    acc_in = 1'b0;
`endif
    exp_prod = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready1", 16'(ready1), 16'd1);
    chk("rst_ready4", 16'(ready4), 16'd1);
    chk("rst_done1", 16'(done1), 16'd0);
    chk("rst_prod1", prod1, 16'h0000);
    chk("rst_prod4", prod4, 16'h0000);
    reset = 1'b1;

    // Unsigned directed cases
    run_op(8'h02, 8'h03, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    run_op(8'hAA, 8'hAA, 1'b0, 1'b0);
    // Signed directed cases, including the most-negative squared
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(8'h80, 8'h7F, 1'b1, 1'b0);
    run_op(8'h80, 8'h80, 1'b1, 1'b0);
    run_op(8'h0F, 8'h11, 1'b0, 1'b0);

    // Back-to-back on the R=4 instance: start held, ready high one cycle between ops
    @(negedge clk);
    ba = {8'h11, 8'h0F}; sgn_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rpat[c] = ready4;
    end
    start = 1'b0;
    chk("b2b_ready4", 16'(rpat), 16'h0024);
    chk("b2b_prod4", prod4, 16'h00FF);
    waited = 0;
    while (!ready1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("b2b_timeout", 16'(ready1), 16'd1);
    chk("b2b_prod1", prod1, 16'h00FF);
    repeat (2) @(negedge clk);

    // Reset three cycles into busy aborts the operation
    ba = {8'h07, 8'h09}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready1", 16'(ready1), 16'd1);
    chk("abort_prod1", prod1, 16'h0000);
    chk("abort_prod4", prod4, 16'h0000);
    chk("abort_done1", 16'(done1), 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("abort_nodone1", 16'({done1, ready1}), 16'h0001);
    end
    exp_prod = '0;
    run_op(8'h05, 8'h05, 1'b0, 1'b0);

`ifdef MUL_ACC_EN
    run_op(8'h02, 8'h03, 1'b0, 1'b0);
    run_op(8'h04, 8'h05, 1'b0, 1'b1);
    run_op(8'hFF, 8'h01, 1'b1, 1'b1);
`endif

    // Randomized operations
    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
`ifdef MUL_ACC_EN
      rc = 1'($urandom);
`else
      rc = 1'b0;
`endif
      run_op(ra, rb, rs, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
